// File: rtl/ex_muldiv_unit_pkg.sv
// Shared decoded-instruction ids (same encoding as ID/EX and decode) plus
// small helpers for classifying the M-extension ops.
package ex_muldiv_unit_pkg;

  localparam logic [5:0] INSTR_NOP    = 6'd0;
  localparam logic [5:0] INSTR_ADD    = 6'd1;
  localparam logic [5:0] INSTR_SUB    = 6'd2;
  localparam logic [5:0] INSTR_AND    = 6'd3;
  localparam logic [5:0] INSTR_OR     = 6'd4;
  localparam logic [5:0] INSTR_XOR    = 6'd5;
  localparam logic [5:0] INSTR_MUL    = 6'd32;
  localparam logic [5:0] INSTR_MULH   = 6'd33;
  localparam logic [5:0] INSTR_MULHSU = 6'd34;
  localparam logic [5:0] INSTR_MULHU  = 6'd35;
  localparam logic [5:0] INSTR_DIV    = 6'd36;
  localparam logic [5:0] INSTR_DIVU   = 6'd37;
  localparam logic [5:0] INSTR_REM    = 6'd38;
  localparam logic [5:0] INSTR_REMU   = 6'd39;

  function automatic logic is_md_instr(input logic [5:0] id);
    return id inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
                      INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU};
  endfunction

  function automatic logic is_div_instr(input logic [5:0] id);
    return id inside {INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU};
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_iter_core.sv
// Radix-2 datapath shared by multiply and divide: a 64-bit {hi,lo} register
// holds {partial product, multiplier} or {remainder, dividend/quotient}.
module muldiv_iter_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_step,
  input  logic        i_div,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_acc_nxt
);

  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_div;

  logic [32:0] w_msum;
  logic [32:0] w_trial;
  logic [32:0] w_rem;
  logic        w_ge;

  always_comb begin
    w_msum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    // Restoring divide: remainder stays below divisor, so hi never overflows.
    w_trial = {r_acc[63:32], r_acc[31]};
    w_ge    = (w_trial >= {1'b0, r_b});
    w_rem   = w_ge ? (w_trial - {1'b0, r_b}) : w_trial;
    if (r_div) o_acc_nxt = {w_rem[31:0], r_acc[30:0], w_ge};
    else       o_acc_nxt = {w_msum, r_acc[31:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_acc <= {32'd0, i_a};
      r_b   <= i_b;
      r_div <= i_div;
    end else if (i_step) begin
      r_acc <= o_acc_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: stalls the front end
// while computing, then presents a registered result with a strobe.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [5:0]  instr_id_in,
  input  logic [31:0] rs1_value_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        flush,
  input  logic        hold_in,
  output logic        stall_out,
  output logic        result_valid_out,
  output logic [31:0] result_out,
  output logic [4:0]  rd_addr_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [4:0]       r_rd;

  logic        w_is_md, w_is_div, w_accept;
  logic        w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [31:0] w_a_mag, w_b_mag, w_fast_res, w_calc_res;
  logic [63:0] w_acc_nxt, w_prod;

  always_comb begin
    w_is_md  = is_md_instr(instr_id_in);
    w_is_div = is_div_instr(instr_id_in);
    w_a_neg  = rs1_value_in[31] &&
               (instr_id_in inside {INSTR_MULH, INSTR_MULHSU, INSTR_DIV, INSTR_REM});
    w_b_neg  = rs2_value_in[31] && (instr_id_in inside {INSTR_MULH, INSTR_DIV, INSTR_REM});
    w_a_mag  = w_a_neg ? -rs1_value_in : rs1_value_in;
    w_b_mag  = w_b_neg ? -rs2_value_in : rs2_value_in;
    w_div0   = w_is_div && (rs2_value_in == 32'd0);
    w_ovf    = (instr_id_in inside {INSTR_DIV, INSTR_REM}) &&
               (rs1_value_in == 32'h8000_0000) && (rs2_value_in == 32'hFFFF_FFFF);
    if (instr_id_in inside {INSTR_DIV, INSTR_DIVU})
      w_fast_res = w_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
    else
      w_fast_res = w_div0 ? rs1_value_in : 32'd0;
    w_accept  = (r_state == S_IDLE) && valid_in && w_is_md && !flush;
    stall_out = w_accept || (r_state == S_CALC);
  end

  muldiv_iter_core u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept),
    .i_step    (r_state == S_CALC),
    .i_div     (w_is_div),
    .i_a       (w_a_mag),
    .i_b       (w_b_mag),
    .o_acc_nxt (w_acc_nxt)
  );

  // Result is taken from the final step's next value so DONE starts valid.
  always_comb begin
    w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    case (r_op)
      INSTR_MUL:                            w_calc_res = w_prod[31:0];
      INSTR_MULH, INSTR_MULHSU, INSTR_MULHU: w_calc_res = w_prod[63:32];
      INSTR_DIV, INSTR_DIVU:
        w_calc_res = r_neg_q ? -w_acc_nxt[31:0] : w_acc_nxt[31:0];
      default:
        w_calc_res = r_neg_r ? -w_acc_nxt[63:32] : w_acc_nxt[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_op             <= '0;
      r_neg_q          <= 1'b0;
      r_neg_r          <= 1'b0;
      r_rd             <= '0;
      result_valid_out <= 1'b0;
      result_out       <= '0;
      rd_addr_out      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          result_valid_out <= 1'b0;
          if (w_accept) begin
            r_op    <= instr_id_in;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_rd    <= rd_addr_in;
            if (w_div0 || w_ovf) begin
              r_state          <= S_DONE;
              result_valid_out <= 1'b1;
              result_out       <= w_fast_res;
              rd_addr_out      <= rd_addr_in;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= '0;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_W'(31)) begin
            r_state          <= S_DONE;
            result_valid_out <= 1'b1;
            result_out       <= w_calc_res;
            rd_addr_out      <= r_rd;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (flush || !hold_in) begin
            r_state          <= S_IDLE;
            result_valid_out <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [5:0]  instr_id_in;
  logic [31:0] rs1_value_in, rs2_value_in;
  logic [4:0]  rd_addr_in;
  logic        flush, hold_in;
  logic        stall_out, result_valid_out;
  logic [31:0] result_out;
  logic [4:0]  rd_addr_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.CNT_W(6)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_in         (valid_in),
    .instr_id_in      (instr_id_in),
    .rs1_value_in     (rs1_value_in),
    .rs2_value_in     (rs2_value_in),
    .rd_addr_in       (rd_addr_in),
    .flush            (flush),
    .hold_in          (hold_in),
    .stall_out        (stall_out),
    .result_valid_out (result_valid_out),
    .result_out       (result_out),
    .rd_addr_out      (rd_addr_out)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_md(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      INSTR_MUL:    begin p = sa * sb; return p[31:0];  end
      INSTR_MULH:   begin p = sa * sb; return p[63:32]; end
      INSTR_MULHSU: begin p = sa * ub; return p[63:32]; end
      INSTR_MULHU:  begin p = ua * ub; return p[63:32]; end
      INSTR_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      INSTR_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ia % ib;
      end
      INSTR_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_stall(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (is_div_instr(op) && b == 0) return 1;
    if ((op == INSTR_DIV || op == INSTR_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Issue one op, keep it in ID/EX while stalled, check result, rd, stall length.
  task automatic do_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] exp, input int exp_stall);
    int  stl = 0;
    bit  seen = 0;
    @(negedge clk);
    valid_in = 1'b1; instr_id_in = op; rs1_value_in = a; rs2_value_in = b; rd_addr_in = rd;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (result_valid_out) begin seen = 1; break; end
      if (stall_out) stl++;
      @(negedge clk);
    end
    valid_in = 1'b0;
    if (!seen) begin
      chk({nm, " timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, " result"}, result_out, exp);
    chk({nm, " rd"}, {27'd0, rd_addr_out}, {27'd0, rd});
    chk({nm, " stall_cycles"}, stl, exp_stall);
    @(negedge clk); #1;
    chk({nm, " strobe_one_cycle"}, {31'd0, result_valid_out}, 32'd0);
  endtask

  task automatic wait_strobe(input string nm, output bit ok);
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (result_valid_out) begin ok = 1; break; end
    end
    if (!ok) chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[$];

  initial begin
    bit ok;
    int strobes;
    rst_n = 1'b0; valid_in = 1'b0; instr_id_in = INSTR_NOP;
    rs1_value_in = '0; rs2_value_in = '0; rd_addr_in = '0; flush = 1'b0; hold_in = 1'b0;

    vt.push_back('{INSTR_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vt.push_back('{INSTR_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vt.push_back('{INSTR_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vt.push_back('{INSTR_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
    vt.push_back('{INSTR_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    vt.push_back('{INSTR_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    vt.push_back('{INSTR_DIVU,   32'd100,        32'd7,         32'd14,        33});
    vt.push_back('{INSTR_REMU,   32'd100,        32'd7,         32'd2,         33});
    vt.push_back('{INSTR_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vt.push_back('{INSTR_REM,    32'd5,          32'd0,         32'd5,         1});
    vt.push_back('{INSTR_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vt.push_back('{INSTR_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

    repeat (3) @(negedge clk);
    #1;
    chk("reset result_valid", {31'd0, result_valid_out}, 32'd0);
    chk("reset result", result_out, 32'd0);
    chk("reset rd", {27'd0, rd_addr_out}, 32'd0);
    chk("reset stall", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;

    foreach (vt[i])
      do_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 5'(i + 1),
            vt[i].exp, vt[i].exp_stall);

    // Flush during CALC: no strobe, unit idle, following ADD not stalled.
    @(negedge clk);
    valid_in = 1'b1; instr_id_in = INSTR_MUL; rs1_value_in = 32'd3; rs2_value_in = 32'd4;
    rd_addr_in = 5'd20;
    repeat (10) @(negedge clk);
    flush = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    flush = 1'b0; #1;
    chk("flush stall", {31'd0, stall_out}, 32'd0);
    chk("flush strobe", {31'd0, result_valid_out}, 32'd0);
    valid_in = 1'b1; instr_id_in = INSTR_ADD; #1;
    chk("add not stalled", {31'd0, stall_out}, 32'd0);
    strobes = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (result_valid_out) strobes++;
    end
    valid_in = 1'b0;
    chk("flush no strobe later", strobes, 0);

    // hold_in for 3 cycles at DONE stretches strobe to 4 cycles.
    @(negedge clk);
    valid_in = 1'b1; instr_id_in = INSTR_DIVU; rs1_value_in = 32'd100; rs2_value_in = 32'd7;
    rd_addr_in = 5'd9;
    wait_strobe("hold", ok);
    valid_in = 1'b0;
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        hold_in = (k < 3);
        #1;
        chk($sformatf("hold strobe%0d", k), {31'd0, result_valid_out}, 32'd1);
        chk($sformatf("hold value%0d", k), result_out, 32'd14);
        @(negedge clk);
      end
      #1;
      chk("hold strobe end", {31'd0, result_valid_out}, 32'd0);
    end
    hold_in = 1'b0;

    // Reset in the middle of CALC clears everything at once.
    @(negedge clk);
    valid_in = 1'b1; instr_id_in = INSTR_MUL; rs1_value_in = 32'd5; rs2_value_in = 32'd6;
    rd_addr_in = 5'd3;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; valid_in = 1'b0; #1;
    chk("midrst result", result_out, 32'd0);
    chk("midrst rd", {27'd0, rd_addr_out}, 32'd0);
    chk("midrst strobe", {31'd0, result_valid_out}, 32'd0);
    chk("midrst stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      op = INSTR_MUL + 6'($urandom_range(0, 7));
      a  = rnd_opnd();
      b  = rnd_opnd();
      do_op($sformatf("rnd%0d op%0d a=%08h b=%08h", i, op, a, b), op, a, b,
            5'($urandom_range(1, 31)), ref_md(op, a, b), ref_stall(op, a, b));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage. It consumes the decoded instruction held in the ID/EX pipeline register and, for the eight M-extension instructions, computes the result over multiple cycles. While it works it raises a stall request that freezes the front end and the ID/EX register. It hands a single-cycle result strobe, the result and the destination register to the EX/MEM writeback mux.

## Interface
Parameters:
- `CNT_W`, default 6: iteration counter width; must hold 32.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  the ID/EX entry holds a real instruction.
- `instr_id_in`  in  6  decoded instruction id, same encoding as ID/EX.
- `rs1_value_in`  in  32  forwarded rs1 operand.
- `rs2_value_in`  in  32  forwarded rs2 operand.
- `rd_addr_in`  in  5  destination register.
- `flush`  in  1  pipeline flush, e.g. a branch mispredict.
- `hold_in`  in  1  downstream is frozen (cache stall).
- `stall_out`  out  1  stall request to the hazard unit; combinational.
- `result_valid_out`  out  1  result strobe.
- `result_out`  out  32  result value.
- `rd_addr_out`  out  5  destination register of the result.

## Operation
- `is_md` = `instr_id_in` ∈ {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU}.
- FSM states: IDLE, CALC, DONE. Reset state is IDLE; all outputs reset to 0.
- IDLE:
  - if `valid_in && is_md && !flush`: latch the op, operand magnitudes, sign flags and `rd_addr_in`.
  - Division by zero or signed overflow (0x80000000 / 0xFFFFFFFF) goes straight to DONE. All other ops go to CALC with counter = 0.
- CALC:
  - One radix-2 step per cycle, 32 steps. The counter increments each step; at counter = 31 go to DONE.
  - Multiply: shift-add into a 64-bit accumulator using unsigned magnitudes.
  - Divide: restoring step with 33-bit remainder compare and subtract.
- DONE: `result_valid_out` = 1. Stay in DONE while `hold_in`, otherwise go to IDLE.
- Result selection:
  - MUL: low 32 bits of the signed-corrected product.
  - MULH, MULHSU, MULHU: high 32 bits.
  - Product negated when the operand signs differ. rs1 counts as signed for MULH and MULHSU; rs2 counts as signed only for MULH.
  - DIV, REM: magnitudes computed unsigned. Quotient negated when the signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - Overflow: quotient = 0x80000000, remainder = 0.
- Flush: in CALC or DONE, return to IDLE next edge with no result strobe. Flush has priority over `hold_in`.
- Reset mid-operation: immediate return to IDLE, outputs 0.
- Non-M instructions: ignored and never stalled.

## Timing
- `stall_out` = (IDLE && `valid_in` && `is_md` && !`flush`) || CALC.
  - It rises in the acceptance cycle so the ID/EX register holds the instruction.
  - It is low in DONE, so ID/EX advances on the DONE edge and the same instruction is never re-accepted.
- Normal op: accept at cycle 0, CALC cycles 1–32, DONE at cycle 33. `stall_out` is high for 33 cycles.
- Fast path (divide by zero or overflow): accept at cycle 0, DONE at cycle 1. `stall_out` is high for 1 cycle.
- `result_out` and `rd_addr_out` are registered and stable throughout DONE. Outside DONE they keep their last value.
- `result_valid_out` is high exactly one cycle per op, extended while `hold_in` = 1.

## Structure
- The shared instruction-id package (same constants ID/EX and decode use) owns the INSTR_MUL … INSTR_REMU ids.
- The FSM state encoding stays local to this block.
- One sub-module, `muldiv_iter_core`, holds the accumulator, remainder and step datapath. It is controlled by start/step/op inputs from the FSM wrapper.

## Test plan
- MUL 7 × −3 (0xFFFFFFFD) → after 33 stall cycles, result 0xFFFFFFEB with a one-cycle strobe in cycle 33; correct `rd_addr_out`.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, both with `stall_out` high one cycle only. DIV 0x80000000 / −1 → 0x80000000 and REM → 0.
- Flush at CALC cycle 10 → IDLE next cycle, no strobe, `stall_out` low. A following ADD is not stalled.
- `hold_in` high for 3 cycles at DONE → strobe held for 4 cycles with stable value. `rst_n` low during CALC → all outputs 0 immediately.
